// File: rtl/lane_vrf_pkg.sv
// Shared VRF write-request types and field widths for the lane write path.
package lane_vrf_pkg;

    localparam int VRF_VD_W        = 5;
    localparam int VRF_OFFSET_W    = 4;
    localparam int VRF_MASK_W      = 4;
    localparam int VRF_DATA_W      = 32;
    localparam int VRF_INST_W      = 3;
    localparam int VRF_WRITE_REQ_W = 49;

    // vd occupies the MSBs, instructionIndex the LSBs of the packed beat
    typedef struct packed {
        logic [VRF_VD_W-1:0]     vd;
        logic [VRF_OFFSET_W-1:0] offset;
        logic [VRF_MASK_W-1:0]   mask;
        logic [VRF_DATA_W-1:0]   data;
        logic                    last;
        logic [VRF_INST_W-1:0]   instructionIndex;
    } vrf_write_req_t;

endpackage

// File: rtl/lane_vrf_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic [N-1:0]     onehot,
    output logic             any
);

    logic [N-1:0]   rot_s;
    logic [PTR_W:0] sum_s;

    // Rotate so ptr lands at bit 0, take lowest set bit, then un-rotate modulo N.
    always_comb begin
        rot_s = N'({req, req} >> ptr);
        any   = |req;
        sum_s = {1'b0, ptr};
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                sum_s = {1'b0, ptr} + (PTR_W + 1)'(k);
            end else begin
                sum_s = sum_s;
            end
        end
        if (sum_s >= (PTR_W + 1)'(N)) begin
            winner = PTR_W'(sum_s - (PTR_W + 1)'(N));
        end else begin
            winner = sum_s[PTR_W-1:0];
        end
        onehot = any ? ({{(N - 1){1'b0}}, 1'b1} << winner) : {N{1'b0}};
    end

endmodule

// File: rtl/lane_vrf_write_arbiter.sv
// Round-robin arbiter sharing the lane VRF write port through one registered output slot.
// Optional per-requester grant / stall statistics when LANE_VRF_WARB_STATS_EN is defined.
module lane_vrf_write_arbiter
    import lane_vrf_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter bit ZERO_MASK_DROP = 1'b1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*VRF_WRITE_REQ_W-1:0]   req_bits,
    input  logic                                 vrfWriteRequest_ready,
    output logic                                 vrfWriteRequest_valid,
    output logic [VRF_VD_W-1:0]                  vrfWriteRequest_bits_vd,
    output logic [VRF_OFFSET_W-1:0]              vrfWriteRequest_bits_offset,
    output logic [VRF_MASK_W-1:0]                vrfWriteRequest_bits_mask,
    output logic [VRF_DATA_W-1:0]                vrfWriteRequest_bits_data,
    output logic                                 vrfWriteRequest_bits_last,
    output logic [VRF_INST_W-1:0]                vrfWriteRequest_bits_instructionIndex,
    output logic [NUM_REQ-1:0]                   grant_onehot
`ifdef LANE_VRF_WARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]                grant_count,
    output logic [15:0]                          stall_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    vrf_write_req_t     req_s [NUM_REQ];
    vrf_write_req_t     win_req_s;
    vrf_write_req_t     slot_q, slot_d;
    logic               out_valid_q, out_valid_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   winner_s;
    logic [NUM_REQ-1:0] win_onehot_s;
    logic [NUM_REQ-1:0] accept_vec_s;
    logic               any_valid_s, slot_free_s, drop_s, accept_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_s[g] = req_bits[g*VRF_WRITE_REQ_W +: VRF_WRITE_REQ_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (winner_s),
        .onehot (win_onehot_s),
        .any    (any_valid_s)
    );

    // Accept/drop decision and next state of slot and round-robin pointer.
    always_comb begin
        win_req_s   = req_s[winner_s];
        slot_free_s = ~out_valid_q | vrfWriteRequest_ready;
        // A masked-off, non-last beat writes nothing, so it never needs the slot
        drop_s      = ZERO_MASK_DROP && (win_req_s.mask == {VRF_MASK_W{1'b0}}) && !win_req_s.last;
        accept_s    = any_valid_s & (slot_free_s | drop_s) & ~reset;
        accept_vec_s = accept_s ? win_onehot_s : {NUM_REQ{1'b0}};

        slot_d      = slot_q;
        rr_ptr_d    = rr_ptr_q;
        if (out_valid_q && vrfWriteRequest_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            if (winner_s == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = {PTR_W{1'b0}};
            end else begin
                rr_ptr_d = winner_s + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            if (!drop_s) begin
                slot_d      = win_req_s;
                out_valid_d = 1'b1;
            end else begin
                slot_d      = slot_q;
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Output slot and pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            slot_q      <= {VRF_WRITE_REQ_W{1'b0}};
            rr_ptr_q    <= {PTR_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            slot_q      <= slot_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign req_ready                             = accept_vec_s;
    assign grant_onehot                          = accept_vec_s;
    assign vrfWriteRequest_valid                 = out_valid_q;
    assign vrfWriteRequest_bits_vd               = slot_q.vd;
    assign vrfWriteRequest_bits_offset           = slot_q.offset;
    assign vrfWriteRequest_bits_mask             = slot_q.mask;
    assign vrfWriteRequest_bits_data             = slot_q.data;
    assign vrfWriteRequest_bits_last             = slot_q.last;
    assign vrfWriteRequest_bits_instructionIndex = slot_q.instructionIndex;

`ifdef LANE_VRF_WARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] grant_cnt_d [NUM_REQ];
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: accepted beats per requester, and stalled output cycles.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_vec_s[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'h0001;
            end else begin
                grant_cnt_d[i] = grant_cnt_q[i];
            end
        end
        if (out_valid_q && !vrfWriteRequest_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= 16'h0000;
            end
            stall_cnt_q <= 16'h0000;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats_pack
        assign grant_count[g*16 +: 16] = grant_cnt_q[g];
    end
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// Directed plus randomized bench for lane_vrf_write_arbiter against a behavioural reference model.
module tb_lane_vrf_write_arbiter;
    import lane_vrf_pkg::*;

    localparam int N = 4;

    logic                           clock = 1'b0;
    logic                           reset;
    logic [N-1:0]                   req_valid;
    logic [N-1:0]                   req_ready;
    logic [N*VRF_WRITE_REQ_W-1:0]   req_bits;
    logic                           vready;
    logic                           vrfWriteRequest_valid;
    logic [VRF_VD_W-1:0]            vrfWriteRequest_bits_vd;
    logic [VRF_OFFSET_W-1:0]        vrfWriteRequest_bits_offset;
    logic [VRF_MASK_W-1:0]          vrfWriteRequest_bits_mask;
    logic [VRF_DATA_W-1:0]          vrfWriteRequest_bits_data;
    logic                           vrfWriteRequest_bits_last;
    logic [VRF_INST_W-1:0]          vrfWriteRequest_bits_instructionIndex;
    logic [N-1:0]                   grant_onehot;
`ifdef LANE_VRF_WARB_STATS_EN
    logic [N*16-1:0]                grant_count;
    logic [15:0]                    stall_count;
`endif

    vrf_write_req_t bq [N];

    // Reference model state: expected output slot and round-robin pointer.
    int             m_ptr;
    logic           m_valid;
    vrf_write_req_t m_bits;

    int checks = 0;
    int errors = 0;
    int w;
    int last_w;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_bits[i*VRF_WRITE_REQ_W +: VRF_WRITE_REQ_W] = bq[i];
        end
    end

    lane_vrf_write_arbiter #(.NUM_REQ(N), .ZERO_MASK_DROP(1'b1)) dut (
        .clock                                 (clock),
        .reset                                 (reset),
        .req_valid                             (req_valid),
        .req_ready                             (req_ready),
        .req_bits                              (req_bits),
        .vrfWriteRequest_ready                 (vready),
        .vrfWriteRequest_valid                 (vrfWriteRequest_valid),
        .vrfWriteRequest_bits_vd               (vrfWriteRequest_bits_vd),
        .vrfWriteRequest_bits_offset           (vrfWriteRequest_bits_offset),
        .vrfWriteRequest_bits_mask             (vrfWriteRequest_bits_mask),
        .vrfWriteRequest_bits_data             (vrfWriteRequest_bits_data),
        .vrfWriteRequest_bits_last             (vrfWriteRequest_bits_last),
        .vrfWriteRequest_bits_instructionIndex (vrfWriteRequest_bits_instructionIndex),
        .grant_onehot                          (grant_onehot)
`ifdef LANE_VRF_WARB_STATS_EN
        ,
        .grant_count                           (grant_count),
        .stall_count                           (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vrf_write_req_t mk(input logic [4:0] vd, input logic [3:0] mask,
                                          input logic [31:0] data, input logic last);
        vrf_write_req_t b;
        b.vd = vd; b.offset = 4'h7; b.mask = mask; b.data = data; b.last = last;
        b.instructionIndex = 3'h5;
        return b;
    endfunction

    function automatic vrf_write_req_t rand_beat();
        vrf_write_req_t b;
        b.vd               = 5'($urandom);
        b.offset           = 4'($urandom);
        b.mask             = ($urandom_range(3, 0) == 0) ? 4'h0 : 4'($urandom);
        b.data             = $urandom;
        b.last             = 1'($urandom_range(1, 0));
        b.instructionIndex = 3'($urandom);
        return b;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_bits  = {VRF_WRITE_REQ_W{1'b0}};
    endtask

    task automatic check_out();
        chk("out_valid", {63'd0, vrfWriteRequest_valid}, {63'd0, m_valid});
        chk("out_bits", {15'd0, vrfWriteRequest_bits_vd, vrfWriteRequest_bits_offset,
                         vrfWriteRequest_bits_mask, vrfWriteRequest_bits_data,
                         vrfWriteRequest_bits_last, vrfWriteRequest_bits_instructionIndex},
            {15'd0, m_bits});
        chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
    endtask

    // One clock: inputs already driven at the falling edge; returns accepted index or -1.
    task automatic cycle(output int w_out);
        int win;
        logic drop, acc, nv;
        logic [N-1:0] e;
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        drop = (win >= 0) && (bq[win].mask == 4'h0) && !bq[win].last;
        acc  = (win >= 0) && ((!m_valid || vready) || drop);
        e = '0;
        if (acc) e[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(e));
        chk("grant_onehot", 64'(grant_onehot), 64'(e));
        nv = (m_valid && vready) ? 1'b0 : m_valid;
        if (acc) begin
            m_ptr = (win + 1) % N;
            if (!drop) begin
                m_bits = bq[win];
                nv = 1'b1;
            end
        end
        m_valid = nv;
        w_out = acc ? win : -1;
        @(negedge clock);
        check_out();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        vready = 1'b0;
        for (int i = 0; i < N; i++) bq[i] = mk(5'(i + 1), 4'hF, 32'h1000 + i, 1'b0);
        model_reset();
        @(negedge clock);
        req_valid = 4'hF;
        #1;
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_grant", 64'(grant_onehot), 64'h0);
        @(negedge clock);
        check_out();
        req_valid = '0;
        reset = 1'b0;

        // All requesters valid, port never stalled: strict rotation.
        req_valid = 4'hF;
        vready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(w);
            chk("rr_seq", 64'(w), 64'(i % N));
            chk("rr_vd", 64'(vrfWriteRequest_bits_vd), 64'((i % N) + 1));
        end

        // Single beat held under back-pressure, then drain+refill in one cycle.
        req_valid = '0;
        cycle(w);
        req_valid = 4'b0100;
        bq[2] = mk(5'h3, 4'hF, 32'hDEADBEEF, 1'b0);
        bq[2].offset = 4'h7;
        vready = 1'b0;
        cycle(w);
        chk("stall_accept", 64'(w), 64'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(w);
            chk("stall_noaccept", 64'(w), -64'sd1);
            chk("stall_data", 64'(vrfWriteRequest_bits_data), 64'hDEADBEEF);
        end
        vready = 1'b1;
        bq[2].data = 32'h12345678;
        cycle(w);
        chk("refill_accept", 64'(w), 64'd2);
        chk("refill_data", 64'(vrfWriteRequest_bits_data), 64'h12345678);

        // Zero-mask drop while stalled; zero-mask last beat is forwarded.
        vready = 1'b0;
        req_valid = 4'b0010;
        bq[1] = mk(5'h9, 4'h0, 32'hCAFEF00D, 1'b0);
        cycle(w);
        chk("drop_accept", 64'(w), 64'd1);
        chk("drop_ptr", 64'(dut.rr_ptr_q), 64'd2);
        chk("drop_hold", 64'(vrfWriteRequest_bits_data), 64'h12345678);
        bq[1].last = 1'b1;
        vready = 1'b1;
        cycle(w);
        chk("last_fwd", 64'(w), 64'd1);
        chk("last_bit", {63'd0, vrfWriteRequest_bits_last}, 64'd1);

        // Wrap-around between requesters 3 and 0.
        req_valid = 4'b0100;
        cycle(w);
        req_valid = 4'b1001;
        bq[0] = mk(5'h10, 4'hA, 32'h0000_00A0, 1'b0);
        bq[3] = mk(5'h13, 4'h5, 32'h0000_00A3, 1'b0);
        cycle(w);
        chk("wrap_0", 64'(w), 64'd3);
        cycle(w);
        chk("wrap_1", 64'(w), 64'd0);
        cycle(w);
        chk("wrap_2", 64'(w), 64'd3);

        // Asynchronous reset between clock edges with a beat in the slot.
        #2;
        reset = 1'b1;
        req_valid = '0;
        #1;
        model_reset();
        check_out();
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic; requesters hold a beat until it is accepted.
        last_w = -1;
        for (int r = 0; r < 1500; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_w == i) begin
                    if ($urandom_range(9, 0) < 6) begin
                        req_valid[i] = 1'b1;
                        bq[i] = rand_beat();
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            vready = ($urandom_range(3, 0) != 0);
            cycle(last_w);
        end

`ifdef LANE_VRF_WARB_STATS_EN
        reset = 1'b1;
        req_valid = '0;
        @(negedge clock);
        model_reset();
        reset = 1'b0;
        req_valid = 4'b0001;
        bq[0] = mk(5'h1, 4'hF, 32'h5A5A5A5A, 1'b0);
        vready = 1'b1;
        for (int i = 0; i < 70000; i++) cycle(w);
        chk("gcnt0_sat", 64'(grant_count[15:0]), 64'hFFFF);
        chk("gcnt_others", 64'(grant_count[N*16-1:16]), 64'h0);
        chk("stall_cnt", 64'(stall_count), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
